// File: rtl/adrf_spi3w_master.sv
`default_nettype none
// ============================================================================
// adrf_spi3w_master : 3-wire SPI initiator for the ADRF6612 register port
// Rev 1.0 : initial release
// ============================================================================
module adrf_spi3w_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ad_spi_cs,
  output logic       ad_spi_sclk,
  inout  wire        ad_spi_sdio
);

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
  localparam logic [7:0] c_gap_last = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  edge_q, edge_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  rshift_q, rshift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        is_read_q, is_read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        oe_q, oe_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    edge_d    = edge_q;
    shift_d   = shift_q;
    rshift_d  = rshift_q;
    rdata_d   = rdata_q;
    is_read_d = is_read_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    oe_d      = oe_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          shift_d   = {rw, addr, wdata};
          is_read_d = rw;
          busy_d    = 1'b1;
          cs_d      = 1'b0;
          oe_d      = 1'b1;
          cnt_d     = 8'd0;
          edge_d    = 5'd0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == c_div_last) begin
          cnt_d   = 8'd0;
          sclk_d  = 1'b1;
          edge_d  = 5'd1;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == c_div_last) begin
          cnt_d = 8'd0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (edge_q == 5'd16) begin
              oe_d    = 1'b0;
              state_d = ST_HOLD;
            end else begin
              shift_d = {shift_q[14:0], 1'b0};
              // Turnaround: the device owns sdio for the data byte of a read
              if (is_read_q && edge_q == 5'd8) begin
                oe_d = 1'b0;
              end
            end
          end else begin
            sclk_d = 1'b1;
            edge_d = edge_q + 5'd1;
            if (is_read_q && edge_q >= 5'd8) begin
              rshift_d = {rshift_q[6:0], ad_spi_sdio};
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == c_div_last) begin
          cnt_d   = 8'd0;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_GAP;
          if (is_read_q) begin
            rdata_d = rshift_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == c_gap_last) begin
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      edge_q    <= 5'd0;
      shift_q   <= 16'd0;
      rshift_q  <= 8'd0;
      is_read_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      oe_q      <= 1'b0;
      // An aborted frame must not disturb the last completed read result
      rdata_q   <= busy_q ? rdata_q : 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      shift_q   <= shift_d;
      rshift_q  <= rshift_d;
      is_read_q <= is_read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      oe_q      <= oe_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign ad_spi_cs   = cs_q;
  assign ad_spi_sclk = sclk_q;
  assign ad_spi_sdio = oe_q ? shift_q[15] : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_adrf_spi3w_master.sv
`default_nettype none
// tb_adrf_spi3w_master : randomized self-checking bench for the 3-wire SPI master
// Rev 1.0 : initial release
module tb_adrf_spi3w_master;

  localparam int H  = 4;
  localparam int G  = 4;
  localparam int H1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic       req, rw, busy, done, cs, sclk;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  wire        sdio;
  logic       s_oe = 1'b0;
  logic       s_bit = 1'b0;
  pullup u_pu_a (sdio);
  assign sdio = s_oe ? s_bit : 1'bz;

  logic       req1, rw1, busy1, done1, cs1, sclk1;
  logic [6:0] addr1;
  logic [7:0] wdata1, rdata1;
  wire        sdio1;
  pullup u_pu_b (sdio1);

  adrf_spi3w_master #(.CLK_DIV(H), .CS_GAP(G)) u_dut (
    .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .ad_spi_cs(cs), .ad_spi_sclk(sclk), .ad_spi_sdio(sdio)
  );

  adrf_spi3w_master #(.CLK_DIV(H1), .CS_GAP(G)) u_dut_div1 (
    .clk(clk), .reset(reset), .req(req1), .rw(rw1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .rdata(rdata1),
    .ad_spi_cs(cs1), .ad_spi_sclk(sclk1), .ad_spi_sdio(sdio1)
  );

  // Event log and device model for the CLK_DIV=4 instance
  logic [7:0]  resp = 8'h00;
  logic [15:0] cap = '0;
  int nbits = 0, nfall = 0, ridx = 7;
  logic drive_pend = 1'b0;
  logic cs_prev = 1'b1, busy_prev = 1'b0, sclk_prev = 1'b0;
  int fall_q[$], rise_q[$], done_q[$], bfall_q[$];
  logic [15:0] frame_q[$];
  int nbits_q[$];

  always @(negedge clk) begin
    if (cs_prev && !cs) begin
      fall_q.push_back(cyc);
      cap = '0; nbits = 0; nfall = 0;
    end
    if (!cs_prev && cs) begin
      rise_q.push_back(cyc);
      frame_q.push_back(cap);
      nbits_q.push_back(nbits);
      s_oe = 1'b0;
      drive_pend = 1'b0;
    end
    if (done) done_q.push_back(cyc);
    if (busy_prev && !busy) bfall_q.push_back(cyc);
    if (!cs) begin
      if (drive_pend) begin
        s_oe = 1'b1; ridx = 7; s_bit = resp[7]; drive_pend = 1'b0;
      end
      if (sclk && !sclk_prev) begin
        cap = {cap[14:0], sdio};
        nbits++;
      end
      if (!sclk && sclk_prev) begin
        nfall++;
        if (nfall == 8 && cap[7]) drive_pend = 1'b1;
        else if (s_oe && nfall < 16) begin
          ridx--;
          s_bit = resp[ridx];
        end
      end
    end
    cs_prev = cs; busy_prev = busy; sclk_prev = sclk;
  end

  // Event log for the CLK_DIV=1 instance
  logic [15:0] cap1 = '0;
  logic cs1_prev = 1'b1, busy1_prev = 1'b0, sclk1_prev = 1'b0;
  int fall1_q[$], rise1_q[$], bfall1_q[$], srise1_q[$];
  logic [15:0] frame1_q[$];

  always @(negedge clk) begin
    if (cs1_prev && !cs1) begin fall1_q.push_back(cyc); cap1 = '0; end
    if (!cs1_prev && cs1) begin rise1_q.push_back(cyc); frame1_q.push_back(cap1); end
    if (busy1_prev && !busy1) bfall1_q.push_back(cyc);
    if (!cs1 && sclk1 && !sclk1_prev) begin
      srise1_q.push_back(cyc);
      cap1 = {cap1[14:0], sdio1};
    end
    cs1_prev = cs1; busy1_prev = busy1; sclk1_prev = sclk1;
  end

  logic [7:0] model_rdata = 8'h00;

  task automatic clear_logs();
    fall_q.delete(); rise_q.delete(); done_q.delete(); bfall_q.delete();
    frame_q.delete(); nbits_q.delete();
    fall1_q.delete(); rise1_q.delete(); bfall1_q.delete(); srise1_q.delete(); frame1_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    repeat (20) @(negedge clk);
    n_tests++; if (cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", cs); end
    n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_tests++; if (sdio !== 1'b1) begin n_fail++; $display("FAIL reset_sdio_released: got %b want pulled 1", sdio); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done_q.size() != 0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d pulses want 0", done_q.size()); end
    n_tests++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
  endtask

  // One full frame on the CLK_DIV=4 instance; r is what the device returns on a read
  task automatic test_transfer(input logic t_rw, input logic [6:0] t_addr,
                               input logic [7:0] t_wdata, input logic [7:0] r);
    int t, last, bad;
    logic [15:0] exp_frame;
    logic [7:0]  exp_rd;
    logic        exp_bit;
    exp_frame = {t_rw, t_addr, t_rw ? r : t_wdata};
    exp_rd    = t_rw ? r : model_rdata;
    resp = r;
    clear_logs();
    req = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata; t = cyc;
    @(negedge clk);
    req = 1'b0;
    // Bit k of the frame is on sdio for the 2H cycles starting at T+1+2kH
    last = t_rw ? t + 16*H + 1 : t + 32*H;
    bad = 0;
    for (int c = t + 1; c <= last; c++) begin
      exp_bit = (t_rw && c == t + 16*H + 1) ? 1'b1 : exp_frame[15 - (c - t - 1) / (2*H)];
      if (sdio !== exp_bit) bad++;
      @(negedge clk);
    end
    while (cyc < t + 33*H + G + 8) @(negedge clk);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL xfer_sdio_bits rw=%b: got %0d bad cycles want 0", t_rw, bad); end
    n_tests++; if (fall_q.size() != 1 || fall_q[0] != t + 1) begin n_fail++; $display("FAIL xfer_cs_fall: got n=%0d at %0d want at %0d", fall_q.size(), fall_q[0], t + 1); end
    n_tests++; if (rise_q.size() != 1 || rise_q[0] != t + 1 + 33*H) begin n_fail++; $display("FAIL xfer_cs_rise: got n=%0d at %0d want at %0d", rise_q.size(), rise_q[0], t + 1 + 33*H); end
    n_tests++; if (done_q.size() != 1 || done_q[0] != t + 1 + 33*H) begin n_fail++; $display("FAIL xfer_done: got n=%0d at %0d want at %0d", done_q.size(), done_q[0], t + 1 + 33*H); end
    n_tests++; if (bfall_q.size() != 1 || bfall_q[0] != t + 1 + 33*H + G) begin n_fail++; $display("FAIL xfer_busy_fall: got n=%0d at %0d want at %0d", bfall_q.size(), bfall_q[0], t + 1 + 33*H + G); end
    n_tests++; if (frame_q.size() != 1 || frame_q[0] !== exp_frame || nbits_q[0] != 16) begin n_fail++; $display("FAIL xfer_frame: got %h (%0d bits) want %h (16 bits)", frame_q[0], nbits_q[0], exp_frame); end
    n_tests++; if (frame_q.size() != 1 || frame_q[0][15:8] !== {t_rw, t_addr}) begin n_fail++; $display("FAIL xfer_header: got %h want %h", frame_q[0][15:8], {t_rw, t_addr}); end
    n_tests++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL xfer_rdata rw=%b: got %h want %h", t_rw, rdata, exp_rd); end
    model_rdata = exp_rd;
  endtask

  task automatic test_back_to_back();
    int t;
    logic [6:0]  a;
    logic [7:0]  r;
    a = 7'($urandom);
    r = 8'($urandom);
    resp = r;
    clear_logs();
    req = 1'b1; rw = 1'b1; addr = a; wdata = 8'($urandom) & 8'h7F; t = cyc;
    // Hold req through the whole first frame and the cycle busy drops
    while (cyc < t + 1 + 33*H + G) @(negedge clk);
    @(negedge clk);
    req = 1'b0;
    while (cyc < t + 2*(33*H + G) + 20) @(negedge clk);
    n_tests++; if (fall_q.size() != 2) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want 2", fall_q.size()); end
    // busy drops CS_GAP cycles after CS rises; the held req is registered one cycle later
    n_tests++; if (fall_q.size() < 2 || rise_q.size() < 1 || fall_q[1] - rise_q[0] != G + 1) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want %0d", fall_q[1] - rise_q[0], G + 1); end
    n_tests++; if (done_q.size() != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_q.size()); end
    n_tests++; if (frame_q.size() != 2 || frame_q[1] !== {1'b1, a, r}) begin n_fail++; $display("FAIL b2b_frame2: got %h want %h", frame_q[1], {1'b1, a, r}); end
    n_tests++; if (rdata !== r) begin n_fail++; $display("FAIL b2b_rdata: got %h want %h", rdata, r); end
    model_rdata = r;
  endtask

  task automatic test_reset_midframe();
    int t, rises, rc;
    logic hit, prev;
    resp = ~model_rdata;
    clear_logs();
    req = 1'b1; rw = 1'b1; addr = 7'($urandom); wdata = 8'h00; t = cyc;
    @(negedge clk);
    req = 1'b0;
    rises = 0; rc = 0; hit = 1'b0; prev = sclk;
    for (int i = 0; i < 20*H && !hit; i++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 5) begin
        hit = 1'b1; rc = cyc; reset = 1'b1;
      end
    end
    n_tests++; if (!hit || rc != t + 1 + 9*H) begin n_fail++; $display("FAIL midrst_edge5: got hit=%b at %0d want at %0d", hit, rc, t + 1 + 9*H); end
    @(negedge clk);
    n_tests++; if (cs !== 1'b1) begin n_fail++; $display("FAIL midrst_cs: got %b want 1", cs); end
    n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
    n_tests++; if (sdio !== 1'b1) begin n_fail++; $display("FAIL midrst_sdio_released: got %b want pulled 1", sdio); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (40*H) @(negedge clk);
    n_tests++; if (done_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_q.size()); end
    n_tests++; if (rdata !== model_rdata) begin n_fail++; $display("FAIL midrst_rdata_kept: got %h want %h", rdata, model_rdata); end
  endtask

  task automatic test_div1();
    int t, bad;
    clear_logs();
    req1 = 1'b1; rw1 = 1'b0; addr1 = 7'h7F; wdata1 = 8'hFF; t = cyc;
    @(negedge clk);
    req1 = 1'b0;
    repeat (60) @(negedge clk);
    bad = 0;
    for (int k = 0; k < srise1_q.size(); k++) begin
      if (srise1_q[k] != t + 1 + (2*k + 1)*H1) bad++;
    end
    n_tests++; if (fall1_q.size() != 1 || fall1_q[0] != t + 1) begin n_fail++; $display("FAIL div1_cs_fall: got %0d want %0d", fall1_q[0], t + 1); end
    n_tests++; if (srise1_q.size() != 16 || bad != 0) begin n_fail++; $display("FAIL div1_sclk_period: got %0d edges %0d off-grid want 16 edges 0 off-grid", srise1_q.size(), bad); end
    n_tests++; if (rise1_q.size() != 1 || rise1_q[0] != t + 34) begin n_fail++; $display("FAIL div1_cs_rise: got %0d want %0d", rise1_q[0], t + 34); end
    n_tests++; if (bfall1_q.size() != 1 || bfall1_q[0] != t + 34 + G) begin n_fail++; $display("FAIL div1_busy_fall: got %0d want %0d", bfall1_q[0], t + 34 + G); end
    n_tests++; if (frame1_q.size() != 1 || frame1_q[0] !== 16'h7FFF) begin n_fail++; $display("FAIL div1_frame: got %h want 7fff", frame1_q[0]); end
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
    req1 = 1'b0; rw1 = 1'b0; addr1 = 7'h00; wdata1 = 8'h00;
    test_reset();
    test_transfer(1'b0, 7'h2A, 8'hC3, 8'h00);
    test_transfer(1'b0, 7'($urandom), 8'($urandom), 8'h00);
    test_transfer(1'b1, 7'h05, 8'h00, 8'hA5);
    test_transfer(1'b1, 7'($urandom), 8'($urandom) & 8'h7F, 8'($urandom));
    test_back_to_back();
    test_reset_midframe();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
